// File: rtl/dbg_bus_pkg.sv
// Shared definitions for the debug-bus host.
//   state_t      : host state machine encoding
//   ST_*         : response frame status byte values
//   DBG_ADDR_RAM : debug-bus address of the RAM debug port
//   FRAME_BYTES  : length of both command and response frames
package dbg_bus_pkg;

    typedef enum logic [2:0] {
        HUNT,
        COLLECT,
        START,
        WAIT_ACC,
        WAIT_AVL,
        SEND
    } state_t;

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_NOACC = 8'hE1;
    localparam logic [7:0] ST_NOAVL = 8'hE2;

    localparam logic [7:0] DBG_ADDR_RAM = 8'd2;

    localparam int FRAME_BYTES = 10;

endpackage

// File: rtl/dbg_bus_host_frame_tx.sv
// dbg_frame_tx: serialises one response frame (header, status, 8 data bytes
// little-endian) over a valid/ready byte handshake.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load               one-cycle strobe: capture hdr/status/rsp and start sending
//   hdr, status, rsp   frame contents
//   tx_data, tx_valid  byte offered to the transmitter
//   tx_ready           transmitter accepts the byte when tx_valid && tx_ready
//   done               one-cycle pulse on acceptance of the last byte
module dbg_frame_tx
    import dbg_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  hdr,
    input  logic [7:0]  status,
    input  logic [63:0] rsp,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    logic [79:0] frame;
    logic [3:0]  idx;
    logic        take;

    assign take = tx_valid && tx_ready;

    // The frame is held in a shift register so the byte on offer is always
    // frame[7:0]; it only moves on a completed handshake, which keeps tx_data
    // stable under backpressure. Shifting in zeros leaves tx_data at 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            frame    <= {rsp, status, hdr};
            idx      <= '0;
            tx_valid <= 1'b1;
        end else if (take) begin
            frame <= {8'h00, frame[79:8]};
            idx   <= idx + 4'd1;
            if (idx == LAST_IDX) begin
                tx_valid <= 1'b0;
            end
        end
    end

    assign tx_data = frame[7:0];
    assign done    = take && (idx == LAST_IDX);

endmodule

// File: rtl/dbg_bus_host.sv
// dbg_bus_host: initiator end of the debug bus. Collects framed commands
// (HDR_CMD, addr, d0..d7) from a UART byte stream, runs one debug-bus
// transaction per command and returns (HDR_RSP, status, r0..r7).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_data, rx_valid          received bytes (no backpressure)
//   tx_data, tx_valid, tx_ready response bytes to the UART transmitter
//   bus_addr, bus_start        device select and one-cycle start strobe
//   bus_data                   shared 64-bit data; driven by the host only in START
//   bus_available, bus_accepted device handshake pulses
//   overrun                    sticky: byte dropped while busy
//   busy                       high outside HUNT and COLLECT
// Build option: define DBG_BUS_HOST_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYC cycles in WAIT_ACC (status E1) or WAIT_AVL (status E2).
module dbg_bus_host
    import dbg_bus_pkg::*;
#(
    parameter logic [7:0]  HDR_CMD     = 8'hA5,
    parameter logic [7:0]  HDR_RSP     = 8'h5A,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  bus_addr,
    output logic        bus_start,
    inout  wire  [63:0] bus_data,
    input  logic        bus_available,
    input  logic        bus_accepted,
    output logic        overrun,
    output logic        busy
);

    state_t      state, state_nx;
    logic [3:0]  byte_cnt;
    logic [7:0]  addr;
    logic [63:0] cmd;
    logic        drive;
    logic        tmo_hit;
    logic        tx_load;
    logic        tx_done;
    logic [7:0]  ld_status;
    logic [63:0] ld_rsp;

    // Releasing depends only on the state register, so an asynchronous reset
    // frees the bus immediately.
    assign bus_data = drive ? cmd : 64'bz;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx = state;
        case (state)
            HUNT:     if (rx_valid && rx_data == HDR_CMD) state_nx = COLLECT;
            COLLECT:  if (rx_valid && byte_cnt == 4'd8)   state_nx = START;
            START:    state_nx = WAIT_ACC;
            WAIT_ACC: begin
                // Accepted and available together: the data is already on the bus.
                if (bus_accepted && bus_available) state_nx = SEND;
                else if (bus_accepted)             state_nx = WAIT_AVL;
                else if (tmo_hit)                  state_nx = SEND;
            end
            WAIT_AVL: if (bus_available || tmo_hit) state_nx = SEND;
            SEND:     if (tx_done) state_nx = HUNT;
            default:  state_nx = HUNT;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus_start = 1'b0;
        drive     = 1'b0;
        busy      = 1'b1;
        tx_load   = 1'b0;
        ld_rsp    = bus_data;
        ld_status = ST_OK;
        case (state)
            HUNT, COLLECT: busy = 1'b0;
            START: begin
                bus_start = 1'b1;
                drive     = 1'b1;
            end
            WAIT_ACC: begin
                if (bus_accepted && bus_available) begin
                    tx_load = 1'b1;
                end else if (!bus_accepted && tmo_hit) begin
                    tx_load   = 1'b1;
                    ld_rsp    = '1;
                    ld_status = ST_NOACC;
                end
            end
            WAIT_AVL: begin
                if (bus_available) begin
                    tx_load = 1'b1;
                end else if (tmo_hit) begin
                    tx_load   = 1'b1;
                    ld_rsp    = '1;
                    ld_status = ST_NOAVL;
                end
            end
            default: ;
        endcase
    end

    // Command collection, held bus address and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            addr     <= '0;
            cmd      <= '0;
            bus_addr <= '0;
            overrun  <= 1'b0;
        end else begin
            if (rx_valid && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                HUNT: begin
                    if (rx_valid && rx_data == HDR_CMD) byte_cnt <= '0;
                end
                COLLECT: begin
                    if (rx_valid) begin
                        // First byte is the address; data bytes arrive d0 first,
                        // so shifting in from the top leaves d0 in cmd[7:0].
                        if (byte_cnt == 4'd0) addr <= rx_data;
                        else                  cmd  <= {rx_data, cmd[63:8]};
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == 4'd8) bus_addr <= addr;
                    end
                end
                SEND: begin
                    if (tx_done) bus_addr <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef DBG_BUS_HOST_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        waiting;

    assign waiting = (state == WAIT_ACC) || (state == WAIT_AVL);

    // Any state change clears the counter, which covers entry to both wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state_nx != state) begin
            tmo_cnt <= '0;
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Fires on the TIMEOUT_CYC-th cycle spent in the wait state.
    assign tmo_hit = waiting && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
    // Without timeouts the host waits for the device indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign tmo_hit            = 1'b0;
`endif

    dbg_frame_tx u_frame_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .hdr      (HDR_RSP),
        .status   (ld_status),
        .rsp      (ld_rsp),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_dbg_bus_host.sv
// Testbench for dbg_bus_host: UART-side stimulus, a behavioural debug-bus
// responder and a frame-level reference model.
module tb_dbg_bus_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  bus_addr;
    logic        bus_start;
    wire  [63:0] bus_data;
    logic        bus_available;
    logic        bus_accepted;
    logic        overrun;
    logic        busy;

    logic        dev_drive = 1'b0;
    logic [63:0] dev_data  = '0;
    assign bus_data = dev_drive ? dev_data : 64'bz;

    always #5 clk = ~clk;

    dbg_bus_host #(.TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .bus_addr      (bus_addr),
        .bus_start     (bus_start),
        .bus_data      (bus_data),
        .bus_available (bus_available),
        .bus_accepted  (bus_accepted),
        .overrun       (overrun),
        .busy          (busy)
    );

    int checks = 0;
    int passed = 0;

    // Responder controls and observations
    bit          resp_on  = 1'b1;
    int          acc_dly  = 1;
    int          avl_dly  = 2;
    bit          same_cyc = 1'b0;
    logic [63:0] rsp_val  = '0;
    bit          resp_active = 1'b0;
    int          start_cnt = 0;
    int          start_hi  = 0;
    logic [7:0]  seen_addr;
    logic [63:0] seen_data;

    // Transmitter controls and captured bytes
    bit          bp_hold  = 1'b0;
    bit          rdy_rand = 1'b0;
    logic [7:0]  txq[$];

    // Behavioural debug-bus device: accepts after acc_dly cycles, then drives
    // rsp_val with an available pulse after avl_dly more cycles.
    initial begin
        bus_accepted  = 1'b0;
        bus_available = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_start === 1'b1) begin
                start_cnt++;
                seen_addr = bus_addr;
                seen_data = bus_data;
                if (resp_on) begin
                    resp_active = 1'b1;
                    @(posedge clk); #1;
                    repeat (acc_dly) begin @(posedge clk); #1; end
                    bus_accepted = 1'b1;
                    if (same_cyc) begin
                        bus_available = 1'b1;
                        dev_data      = rsp_val;
                        dev_drive     = 1'b1;
                    end
                    @(posedge clk); #1;
                    bus_accepted  = 1'b0;
                    bus_available = 1'b0;
                    dev_drive     = 1'b0;
                    if (!same_cyc) begin
                        repeat (avl_dly) begin @(posedge clk); #1; end
                        bus_available = 1'b1;
                        dev_data      = rsp_val;
                        dev_drive     = 1'b1;
                        @(posedge clk); #1;
                        bus_available = 1'b0;
                        dev_drive     = 1'b0;
                    end
                    resp_active = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus_start === 1'b1) start_hi++;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx_data);
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_hold)       tx_ready = 1'b0;
            else if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
            else               tx_ready = 1'b1;
        end
    end

    // Reference frame: header, status, then the response bytes least significant first.
    function automatic logic [79:0] model_frame(input logic [7:0] st, input logic [63:0] r);
        logic [79:0] v;
        v[7:0]  = 8'h5A;
        v[15:8] = st;
        for (int i = 0; i < 8; i++) v[16 + i*8 +: 8] = r[i*8 +: 8];
        return v;
    endfunction

    function automatic logic [79:0] pack_txq();
        logic [79:0] v = '0;
        for (int i = 0; i < txq.size() && i < 10; i++) v[i*8 +: 8] = txq[i];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [63:0] d);
        send_byte(8'hA5);
        send_byte(a);
        for (int i = 0; i < 8; i++) send_byte(d[i*8 +: 8]);
    endtask

    task automatic new_txn();
        txq.delete();
        start_cnt = 0;
        start_hi  = 0;
    endtask

    // Bounded wait for a complete response frame and return to idle.
    task automatic wait_frame();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (txq.size() >= 10 && busy === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else passed++;
        checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
        checks++; if (bus_addr !== 8'h00) $display("FAIL reset_bus_addr: got %h want 00", bus_addr); else passed++;
        checks++; if (bus_start !== 1'b0) $display("FAIL reset_bus_start: got %b want 0", bus_start); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ram_read();
        new_txn();
        acc_dly = 1; avl_dly = 3; same_cyc = 0;
        rsp_val = 64'hFFFF_FFFF_FFFF_FF3C;
        send_cmd(8'h02, 64'h0000_0000_0000_0500);
        wait_frame();
        checks++; if (start_hi !== 1) $display("FAIL read_start_cycles: got %0d want 1", start_hi); else passed++;
        checks++; if (seen_addr !== 8'h02) $display("FAIL read_bus_addr: got %h want 02", seen_addr); else passed++;
        checks++; if (seen_data !== 64'h0000_0000_0000_0500) $display("FAIL read_bus_data: got %h want 0000000000000500", seen_data); else passed++;
        checks++; if (txq.size() !== 10) $display("FAIL read_tx_count: got %0d want 10", txq.size()); else passed++;
        checks++; if (pack_txq() !== 80'hFFFF_FFFF_FFFF_FF3C_005A) $display("FAIL read_frame: got %h want %h", pack_txq(), 80'hFFFF_FFFF_FFFF_FF3C_005A); else passed++;
        checks++; if (bus_addr !== 8'h00) $display("FAIL read_addr_idle: got %h want 00", bus_addr); else passed++;
    endtask

    task automatic test_ram_write();
        new_txn();
        acc_dly = 0; avl_dly = 0; same_cyc = 0;
        rsp_val = 64'd123;
        send_cmd(8'h02, 64'hAB00_0000_0000_0A01);
        wait_frame();
        checks++; if (seen_data !== 64'hAB00_0000_0000_0A01) $display("FAIL write_bus_data: got %h want AB00000000000A01", seen_data); else passed++;
        checks++; if (start_cnt !== 1) $display("FAIL write_start_count: got %0d want 1", start_cnt); else passed++;
        checks++; if (pack_txq() !== model_frame(8'h00, 64'd123)) $display("FAIL write_frame: got %h want %h", pack_txq(), model_frame(8'h00, 64'd123)); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL write_busy_after: got %b want 0", busy); else passed++;
    endtask

    task automatic test_resync();
        logic [63:0] d;
        new_txn();
        d = {$urandom, $urandom};
        rsp_val = {$urandom, $urandom};
        send_byte(8'h11);
        send_byte(8'h22);
        send_cmd(8'h02, d);
        wait_frame();
        repeat (20) @(negedge clk);
        checks++; if (start_cnt !== 1) $display("FAIL resync_start_count: got %0d want 1", start_cnt); else passed++;
        checks++; if (seen_data !== d) $display("FAIL resync_bus_data: got %h want %h", seen_data, d); else passed++;
        checks++; if (pack_txq() !== model_frame(8'h00, rsp_val)) $display("FAIL resync_frame: got %h want %h", pack_txq(), model_frame(8'h00, rsp_val)); else passed++;
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [63:0] d;
        rdy_rand = 1'b1;
        for (int n = 0; n < 10; n++) begin
            new_txn();
            a = 8'($urandom);
            d = {$urandom, $urandom};
            if (n % 2 == 0) d[31:24] = 8'hA5;
            if (n % 3 == 0) begin d[7:0] = 8'h00; d[63:56] = 8'hFF; end
            if (n == 4) a = 8'hFF;
            if (n == 5) a = 8'h00;
            rsp_val  = {$urandom, $urandom};
            acc_dly  = $urandom_range(0, 4);
            avl_dly  = $urandom_range(0, 4);
            same_cyc = ($urandom_range(0, 2) == 0);
            send_cmd(a, d);
            wait_frame();
            checks++; if (start_cnt !== 1) $display("FAIL rand%0d_start_count: got %0d want 1", n, start_cnt); else passed++;
            checks++; if (seen_addr !== a) $display("FAIL rand%0d_addr: got %h want %h", n, seen_addr, a); else passed++;
            checks++; if (seen_data !== d) $display("FAIL rand%0d_data: got %h want %h", n, seen_data, d); else passed++;
            checks++; if (pack_txq() !== model_frame(8'h00, rsp_val)) $display("FAIL rand%0d_frame: got %h want %h", n, pack_txq(), model_frame(8'h00, rsp_val)); else passed++;
        end
        rdy_rand = 1'b0;
        same_cyc = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int         qsz;
        bit         stable;
        new_txn();
        acc_dly = 1; avl_dly = 1;
        rsp_val = 64'h0807_0605_0403_0201;
        send_cmd(8'h02, 64'h1122_3344_5566_7788);
        for (int i = 0; i < 500 && txq.size() < 3; i++) @(negedge clk);
        bp_hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        held   = tx_data;
        qsz    = txq.size();
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_data !== held || tx_valid !== 1'b1) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) $display("FAIL bp_stable: tx_data moved (held %h now %h valid %b)", held, tx_data, tx_valid); else passed++;
        checks++; if (txq.size() !== qsz) $display("FAIL bp_no_transfer: got %0d bytes want %0d", txq.size(), qsz); else passed++;
        bp_hold = 1'b0;
        wait_frame();
        checks++; if (txq.size() !== 10) $display("FAIL bp_tx_count: got %0d want 10", txq.size()); else passed++;
        checks++; if (pack_txq() !== model_frame(8'h00, rsp_val)) $display("FAIL bp_frame: got %h want %h", pack_txq(), model_frame(8'h00, rsp_val)); else passed++;
    endtask

    task automatic test_overrun();
        bit found = 1'b0;
        new_txn();
        acc_dly = 1; avl_dly = 20;
        rsp_val = 64'hDEAD_BEEF_0123_4567;
        checks++; if (overrun !== 1'b0) $display("FAIL ovr_before: got %b want 0", overrun); else passed++;
        send_cmd(8'h02, 64'h0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_accepted === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (found !== 1'b1) $display("FAIL ovr_accept_seen: got %b want 1", found); else passed++;
        repeat (3) @(negedge clk);
        send_byte(8'hA5);
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else passed++;
        wait_frame();
        repeat (20) @(negedge clk);
        checks++; if (pack_txq() !== model_frame(8'h00, rsp_val)) $display("FAIL ovr_frame: got %h want %h", pack_txq(), model_frame(8'h00, rsp_val)); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL ovr_busy_after: got %b want 0", busy); else passed++;
        checks++; if (start_cnt !== 1) $display("FAIL ovr_start_count: got %0d want 1", start_cnt); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        new_txn();
        acc_dly = 0; avl_dly = 30;
        rsp_val = 64'h5555_AAAA_5555_AAAA;
        send_cmd(8'h02, 64'h1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_accepted === 1'b1) begin found = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || bus_start !== 1'b0) $display("FAIL arst_idle: busy %b start %b want 0 0", busy, bus_start); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL arst_overrun: got %b want 0", overrun); else passed++;
        checks++; if (bus_addr !== 8'h00 || tx_valid !== 1'b0) $display("FAIL arst_outputs: addr %h tx_valid %b want 00 0", bus_addr, tx_valid); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200 && resp_active; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++; if (txq.size() !== 0 || busy !== 1'b0) $display("FAIL arst_discard: tx bytes %0d busy %b want 0 0", txq.size(), busy); else passed++;
        new_txn();
        avl_dly = 2;
        rsp_val = 64'h0123_4567_89AB_CDEF;
        send_cmd(8'h02, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_frame();
        checks++; if (seen_data !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL arst_recover_data: got %h want all ones", seen_data); else passed++;
        checks++; if (pack_txq() !== model_frame(8'h00, rsp_val)) $display("FAIL arst_recover_frame: got %h want %h", pack_txq(), model_frame(8'h00, rsp_val)); else passed++;
    endtask

`ifdef DBG_BUS_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int lat = -1;
        new_txn();
        resp_on = 1'b0;
        send_cmd(8'h07, 64'h0102_0304_0506_0708);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus_start === 1'b1) break;
        end
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin lat = i; break; end
        end
        checks++; if (lat !== 17) $display("FAIL tmo_latency: got %0d want 17", lat); else passed++;
        wait_frame();
        checks++; if (pack_txq() !== model_frame(8'hE1, '1)) $display("FAIL tmo_frame: got %h want %h", pack_txq(), model_frame(8'hE1, '1)); else passed++;
        resp_on = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_ram_read();
        test_ram_write();
        test_resync();
        test_random();
        test_backpressure();
`ifdef DBG_BUS_HOST_TIMEOUT_EN
        test_timeout();
`endif
        test_overrun();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
